memcpy_job_queue: RTL and testbench

MEMCPY_JOB_QUEUE -- requirements
Module: memcpy_job_queue

---
 rtl/memcpy_job_queue.sv | 182 ++++++++++++++++++
 tb/tb_memcpy_job_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memcpy_job_queue.sv
// memcpy_job_queue: descriptor FIFO feeding a copy engine with at most one job outstanding.
// Optional build macro MEMCPY_JOB_TIMEOUT_EN adds a WAIT watchdog (timeout_cycles / timeout_err).
//
// state  | meaning
// IDLE   | pop next descriptor; zero-length retires in place, otherwise latch it for the engine
// LAUNCH | memcpy_* operands stable; memcpy_start is registered on the exit edge
// WAIT   | job outstanding; retire on a fresh rising edge of memcpy_done
module memcpy_job_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_src,
  input  logic [ADDR_WIDTH-1:0] desc_tgt,
  input  logic [63:0]           desc_len,
  output logic [ADDR_WIDTH-1:0] memcpy_src_addr,
  output logic [ADDR_WIDTH-1:0] memcpy_tgt_addr,
  output logic [63:0]           memcpy_len,
  output logic                  memcpy_start,
  input  logic                  memcpy_done,
`ifdef MEMCPY_JOB_TIMEOUT_EN
  input  logic [31:0]           timeout_cycles,
  output logic                  timeout_err,
`endif
  output logic                  job_done,
  output logic [15:0]           job_cnt,
  output logic                  busy,
  output logic                  zero_len_err
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = 2 * ADDR_WIDTH + 64;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t                state, state_d;
  logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   fifo_cnt;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] head_src, head_tgt;
  logic [63:0]           head_len;
  logic                  load, start_d, retire, zero_set;
  logic                  done_q, done_rise;

  assign fifo_full  = (fifo_cnt == (DEPTH_LOG2 + 1)'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign desc_ready = ~fifo_full;
  assign push       = desc_valid & ~fifo_full;
  assign {head_src, head_tgt, head_len} = fifo_mem[rd_ptr];
  assign busy       = ~fifo_empty | (state != IDLE);

  // A level still high when WAIT is entered shows done_q=1, so only a new edge retires.
  assign done_rise  = memcpy_done & ~done_q;

`ifdef MEMCPY_JOB_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_hit, tmo_set;

  assign timeout_hit = (timeout_cycles != '0) && ((wait_cnt + 32'd1) == timeout_cycles);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == LAUNCH)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 32'd1;
      if (tmo_set)
        timeout_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {desc_src, desc_tgt, desc_len};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    load     = 1'b0;
    start_d  = 1'b0;
    retire   = 1'b0;
    zero_set = 1'b0;
`ifdef MEMCPY_JOB_TIMEOUT_EN
    tmo_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_len == '0) begin
            retire   = 1'b1;
            zero_set = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
`ifdef MEMCPY_JOB_TIMEOUT_EN
        else if (timeout_hit) begin
          retire  = 1'b1;
          tmo_set = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands only change on a pop, so they stay stable through LAUNCH and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q          <= 1'b0;
      memcpy_src_addr <= '0;
      memcpy_tgt_addr <= '0;
      memcpy_len      <= '0;
      memcpy_start    <= 1'b0;
      job_done        <= 1'b0;
      job_cnt         <= '0;
      zero_len_err    <= 1'b0;
    end else begin
      done_q       <= memcpy_done;
      memcpy_start <= start_d;
      job_done     <= retire;
      if (retire)
        job_cnt <= job_cnt + 16'd1;
      if (zero_set)
        zero_len_err <= 1'b1;
      if (load) begin
        memcpy_src_addr <= head_src;
        memcpy_tgt_addr <= head_tgt;
        memcpy_len      <= head_len;
      end
    end
  end

endmodule

// File: tb/tb_memcpy_job_queue.sv
// Scoreboard bench for memcpy_job_queue: directed descriptors, launch monitor, small engine model.
`timescale 1ns/1ps
module tb_memcpy_job_queue;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] tgt;
    logic [63:0] len;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [63:0] desc_src = '0;
  logic [63:0] desc_tgt = '0;
  logic [63:0] desc_len = '0;
  logic [63:0] memcpy_src_addr, memcpy_tgt_addr, memcpy_len;
  logic        memcpy_start, memcpy_done;
  logic        job_done, busy, zero_len_err;
  logic [15:0] job_cnt;
  logic        man_done = 1'b0;
  logic        eng_done = 1'b0;
`ifdef MEMCPY_JOB_TIMEOUT_EN
  logic [31:0] timeout_cycles = '0;
  logic        timeout_err;
`endif

  assign memcpy_done = man_done | eng_done;

  memcpy_job_queue dut (
    .clk(clk),
    .rst(rst),
    .desc_valid(desc_valid),
    .desc_ready(desc_ready),
    .desc_src(desc_src),
    .desc_tgt(desc_tgt),
    .desc_len(desc_len),
    .memcpy_src_addr(memcpy_src_addr),
    .memcpy_tgt_addr(memcpy_tgt_addr),
    .memcpy_len(memcpy_len),
    .memcpy_start(memcpy_start),
    .memcpy_done(memcpy_done),
`ifdef MEMCPY_JOB_TIMEOUT_EN
    .timeout_cycles(timeout_cycles),
    .timeout_err(timeout_err),
`endif
    .job_done(job_done),
    .job_cnt(job_cnt),
    .busy(busy),
    .zero_len_err(zero_len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_cmp = 0;
  int    n_bad = 0;
  desc_t exp_q[$];
  desc_t mon_e;
  int    start_cnt = 0;
  int    done_seen = 0;
  int    last_start_cyc = 0;
  int    last_done_cyc = -100;
  int    push_cyc = 0;
  bit    eng_auto = 1'b0;
  int    eng_delay = 20;
  int    done_at = -1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Launch monitor: every memcpy_start must match the oldest expected non-zero descriptor.
  always @(negedge clk) begin
    if (memcpy_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      check("start_gap_after_done", 64'(cyc - last_done_cyc >= 2), 64'd1);
      if (exp_q.size() == 0) begin
        check("start_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("launch_src", memcpy_src_addr, mon_e.src);
        check("launch_tgt", memcpy_tgt_addr, mon_e.tgt);
        check("launch_len", memcpy_len, mon_e.len);
      end
    end
    if (job_done) begin
      done_seen++;
      last_done_cyc = cyc;
    end
  end

  // Engine model: one done pulse eng_delay cycles after each start while eng_auto is set.
  always @(negedge clk) begin
    if (eng_auto && memcpy_start)
      done_at = cyc + eng_delay;
    eng_done = eng_auto && (cyc == done_at);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] s, input logic [63:0] t, input logic [63:0] l);
    desc_t e;
    bit    acc;
    acc        = 1'b0;
    desc_valid = 1'b1;
    desc_src   = s;
    desc_tgt   = t;
    desc_len   = l;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = desc_ready;
      @(posedge clk);
      #1;
    end
    check("push_accepted", 64'(acc), 64'd1);
    push_cyc   = cyc;
    desc_valid = 1'b0;
    if (l != 0) begin
      e.src = s;
      e.tgt = t;
      e.len = l;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_start(input int n, input int budget);
    for (int k = 0; k < budget && start_cnt < n; k++) @(posedge clk);
    #1;
    check("start_count", 64'(start_cnt), 64'(n));
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && done_seen < n; k++) @(posedge clk);
    #1;
    check("job_done_count", 64'(done_seen), 64'(n));
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    desc_valid = 1'b0;
    man_done   = 1'b0;
    eng_auto   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  int s0, d0, s1;

  initial begin
    // Reset state
    do_reset();
    check("rst_desc_ready", 64'(desc_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_job_cnt", 64'(job_cnt), 64'd0);
    check("rst_zero_len_err", 64'(zero_len_err), 64'd0);
    check("rst_start", 64'(memcpy_start), 64'd0);
    check("rst_job_done", 64'(job_done), 64'd0);
    check("rst_src", memcpy_src_addr, 64'd0);
    check("rst_len", memcpy_len, 64'd0);

    // Single job, engine answers 20 cycles after start
    eng_auto  = 1'b1;
    eng_delay = 20;
    s0 = start_cnt;
    d0 = done_seen;
    push(64'h1000, 64'h2000, 64'd256);
    wait_start(s0 + 1, 50);
    check("launch_latency", 64'(last_start_cyc - push_cyc), 64'd2);
    wait_done(d0 + 1, 100);
    cycles(2);
    check("single_job_cnt", 64'(job_cnt), 64'd1);
    check("single_busy", 64'(busy), 64'd0);
    check("single_starts", 64'(start_cnt - s0), 64'd1);
    check("held_src", memcpy_src_addr, 64'h1000);
    check("held_tgt", memcpy_tgt_addr, 64'h2000);
    check("held_len", memcpy_len, 64'd256);
    check("single_exp_empty", 64'(exp_q.size()), 64'd0);

    // Full FIFO with a stalled engine
    do_reset();
    s0 = start_cnt;
    d0 = done_seen;
    for (int i = 0; i < 5; i++)
      push(64'h1_0000 + 64'(i) * 64'h100, 64'h8_0000 + 64'(i) * 64'h100, 64'd16 * 64'(i + 1));
    check("full_desc_ready", 64'(desc_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    check("full_one_launched", 64'(start_cnt - s0), 64'd1);
    man_done = 1'b1;
    cycles(1);
    man_done  = 1'b0;
    eng_delay = 4;
    eng_auto  = 1'b1;
    wait_done(d0 + 5, 200);
    cycles(2);
    check("full_job_cnt", 64'(job_cnt), 64'd5);
    check("full_ready_after", 64'(desc_ready), 64'd1);
    check("full_busy_after", 64'(busy), 64'd0);
    check("full_exp_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length descriptor followed by a real one
    do_reset();
    eng_auto  = 1'b1;
    eng_delay = 5;
    s0 = start_cnt;
    d0 = done_seen;
    push(64'h3000, 64'h4000, 64'd0);
    push(64'h5000, 64'h6000, 64'd64);
    wait_done(d0 + 2, 100);
    cycles(2);
    check("zero_len_err", 64'(zero_len_err), 64'd1);
    check("zero_job_cnt", 64'(job_cnt), 64'd2);
    check("zero_starts", 64'(start_cnt - s0), 64'd1);
    check("zero_exp_empty", 64'(exp_q.size()), 64'd0);

    // Engine holds done high between jobs
    do_reset();
    s0 = start_cnt;
    d0 = done_seen;
    push(64'h7000, 64'h7100, 64'd32);
    push(64'h7200, 64'h7300, 64'd48);
    wait_start(s0 + 1, 20);
    cycles(3);
    man_done = 1'b1;
    wait_done(d0 + 1, 20);
    wait_start(s0 + 2, 20);
    cycles(10);
    check("level_no_retire", 64'(done_seen - d0), 64'd1);
    check("level_job_cnt_1", 64'(job_cnt), 64'd1);
    man_done = 1'b0;
    cycles(1);
    man_done = 1'b1;
    wait_done(d0 + 2, 10);
    cycles(1);
    man_done = 1'b0;
    check("level_job_cnt_2", 64'(job_cnt), 64'd2);
    check("level_exp_empty", 64'(exp_q.size()), 64'd0);

    // Reset while a job is outstanding and two are queued
    do_reset();
    s0 = start_cnt;
    for (int i = 0; i < 3; i++)
      push(64'h9000 + 64'(i), 64'hA000 + 64'(i), 64'd8);
    wait_start(s0 + 1, 20);
    cycles(5);
    d0 = done_seen;
    s1 = start_cnt;
    do_reset();
    check("rstwait_busy", 64'(busy), 64'd0);
    check("rstwait_ready", 64'(desc_ready), 64'd1);
    check("rstwait_job_cnt", 64'(job_cnt), 64'd0);
    cycles(10);
    check("rstwait_no_done", 64'(done_seen), 64'(d0));
    check("rstwait_no_start", 64'(start_cnt), 64'(s1));
    check("rstwait_busy_later", 64'(busy), 64'd0);

`ifdef MEMCPY_JOB_TIMEOUT_EN
    // Watchdog retires a job the engine never completes
    do_reset();
    timeout_cycles = 32'd100;
    s0 = start_cnt;
    d0 = done_seen;
    push(64'hB000, 64'hC000, 64'd4);
    wait_start(s0 + 1, 20);
    s1 = last_start_cyc;
    wait_done(d0 + 1, 200);
    check("timeout_latency", 64'(last_done_cyc - s1), 64'd100);
    check("timeout_err", 64'(timeout_err), 64'd1);
    check("timeout_job_cnt", 64'(job_cnt), 64'd1);
    timeout_cycles = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
